// File: rtl/bdemux_10_buf.sv
// ============================================================================
// bdemux_10_buf : buffered 1-to-4 demux; one 2-entry FIFO slot per destination.
// Optional feature macro: DEMUX_BROADCAST_EN (adds in_bcast, all-slot push).
// Revision: 1.0
// ============================================================================
`default_nettype none

module bdemux_10_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
`ifdef DEMUX_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_0,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2,
  output logic [WIDTH-1:0] out_data_3
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slot_state_e;

  slot_state_e      state_q [4];
  slot_state_e      state_d [4];
  logic [WIDTH-1:0] head_q  [4];
  logic [WIDTH-1:0] head_d  [4];
  logic [WIDTH-1:0] tail_q  [4];
  logic [WIDTH-1:0] tail_d  [4];

  logic [3:0] slot_open;
  logic [3:0] push;
  logic [3:0] pop;
  logic       bcast;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A broadcast is all-or-nothing, so every slot must be able to take the word.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (bcast) in_ready = &slot_open;
      else       in_ready = slot_open[in_sel];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign slot_open[i] = (state_q[i] != FULL) || out_ready[i];
    assign out_valid[i] = (state_q[i] != EMPTY);
    assign pop[i]       = out_valid[i] && out_ready[i];
    assign push[i]      = in_valid && in_ready && (bcast || (in_sel == 2'(i)));

    always_comb begin
      state_d[i] = state_q[i];
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      unique case (state_q[i])
        EMPTY: begin
          if (push[i]) begin
            state_d[i] = ONE;
            head_d[i]  = in_data;
          end
        end
        ONE: begin
          if (push[i] && !pop[i]) begin
            state_d[i] = FULL;
            tail_d[i]  = in_data;
          end else if (pop[i] && !push[i]) begin
            state_d[i] = EMPTY;
          end else if (push[i] && pop[i]) begin
            head_d[i]  = in_data;
          end
        end
        FULL: begin
          if (pop[i]) begin
            head_d[i] = tail_q[i];
            if (push[i]) tail_d[i]  = in_data;
            else         state_d[i] = ONE;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q[i] <= EMPTY;
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
      end
    end
  end

  assign out_data_0 = head_q[0];
  assign out_data_1 = head_q[1];
  assign out_data_2 = head_q[2];
  assign out_data_3 = head_q[3];

endmodule

`default_nettype wire

// File: tb/tb_bdemux_10_buf.sv
// Directed bench for bdemux_10_buf; broadcast steps build only with DEMUX_BROADCAST_EN.
`default_nettype none

module tb_bdemux_10_buf;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [9:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [9:0] out_data_0;
  logic [9:0] out_data_1;
  logic [9:0] out_data_2;
  logic [9:0] out_data_3;
`ifdef DEMUX_BROADCAST_EN
  logic       in_bcast;
`endif

  int checks;
  int errors;

  bdemux_10_buf #(.WIDTH(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast   (in_bcast),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data_0 (out_data_0),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_data_3 (out_data_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 10'h000;
    out_ready = 4'b0000;
`ifdef DEMUX_BROADCAST_EN
    in_bcast  = 1'b0;
`endif

    // 1. reset
    tick(); tick();
    check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {28'b0, out_valid}, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", {28'b0, out_valid}, 32'h0);
    check("post_rst_data0", {22'b0, out_data_0}, 32'h0);
    check("post_rst_data1", {22'b0, out_data_1}, 32'h0);
    check("post_rst_data2", {22'b0, out_data_2}, 32'h0);
    check("post_rst_data3", {22'b0, out_data_3}, 32'h0);
    in_valid = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 2. single route to slot 2
    in_sel = 2'd2; in_data = 10'h155;
    tick();
    in_valid = 1'b0;
    check("route_out_valid", {28'b0, out_valid}, 32'h4);
    check("route_data2", {22'b0, out_data_2}, 32'h155);
    check("route_data0", {22'b0, out_data_0}, 32'h0);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    check("route_pop_valid", {28'b0, out_valid}, 32'h0);
    check("route_pop_hold_data2", {22'b0, out_data_2}, 32'h155);

    // 3. backpressure on slot 1
    in_valid = 1'b1; in_sel = 2'd1; in_data = 10'h001;
    tick();
    in_data = 10'h002;
    #1;
    check("bp_ready_second", {31'b0, in_ready}, 32'd1);
    tick();
    in_data = 10'h003;
    #1;
    check("bp_ready_full", {31'b0, in_ready}, 32'd0);
    check("bp_valid1", {28'b0, out_valid}, 32'h2);
    check("bp_head_001", {22'b0, out_data_1}, 32'h001);
    tick();
    check("bp_stall_head", {22'b0, out_data_1}, 32'h001);
    out_ready = 4'b0010;
    #1;
    check("bp_ready_with_pop", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_order_002", {22'b0, out_data_1}, 32'h002);
    tick();
    check("bp_order_003", {22'b0, out_data_1}, 32'h003);
    check("bp_valid_last", {28'b0, out_valid}, 32'h2);
    tick();
    out_ready = 4'b0000;
    check("bp_drained", {28'b0, out_valid}, 32'h0);
    check("bp_hold_last", {22'b0, out_data_1}, 32'h003);

    // 4. cross-slot independence
    in_valid = 1'b1; in_sel = 2'd0; in_data = 10'h00A;
    tick();
    in_data = 10'h00B;
    tick();
    #1;
    check("xs_slot0_full", {31'b0, in_ready}, 32'd0);
    in_sel = 2'd3; in_data = 10'h2AA;
    #1;
    check("xs_ready_slot3", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("xs_out_valid", {28'b0, out_valid}, 32'h9);
    check("xs_data3", {22'b0, out_data_3}, 32'h2AA);
    check("xs_data0_unchanged", {22'b0, out_data_0}, 32'h00A);
    out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    check("xs_slot0_tail", {22'b0, out_data_0}, 32'h00B);

    // 5. async reset mid-operation (slots 0, 2, 3 hold data)
    in_valid = 1'b1; in_sel = 2'd2; in_data = 10'h111;
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", {28'b0, out_valid}, 32'hD);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid_cleared", {28'b0, out_valid}, 32'h0);
    check("ar_ready_low", {31'b0, in_ready}, 32'd0);
    check("ar_data2_cleared", {22'b0, out_data_2}, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("ar_no_stale", {28'b0, out_valid}, 32'h0);
    check("ar_data0_zero", {22'b0, out_data_0}, 32'h0);

`ifdef DEMUX_BROADCAST_EN
    // 6. broadcast, all-or-nothing
    in_valid = 1'b1; in_sel = 2'd0; in_data = 10'h001;
    tick();
    in_data = 10'h002;
    tick();
    in_bcast = 1'b1; in_sel = 2'd3; in_data = 10'h3FF;
    #1;
    check("bc_blocked", {31'b0, in_ready}, 32'd0);
    tick();
    check("bc_no_change", {28'b0, out_valid}, 32'h1);
    out_ready = 4'b0001;
    #1;
    check("bc_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    check("bc_all_valid", {28'b0, out_valid}, 32'hF);
    check("bc_data0_tail", {22'b0, out_data_0}, 32'h002);
    check("bc_data1", {22'b0, out_data_1}, 32'h3FF);
    check("bc_data2", {22'b0, out_data_2}, 32'h3FF);
    check("bc_data3", {22'b0, out_data_3}, 32'h3FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
